// File: rtl/gpio_bus_arbiter_if.sv
// Slave-side bus of the GPIO emulator: address, write data, strobes and read data.
interface gpio_bus_arbiter_if;
  logic [15:0] saddress;
  logic [31:0] sdata_in;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_out;

  modport master (output saddress, sdata_in, srd, swr, input sdata_out);
  modport slave  (input saddress, sdata_in, srd, swr, output sdata_out);
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Two-requester round-robin arbiter driving the GPIO emulator bus with
// setup / strobe / hold phases and a one-cycle acknowledge.
module gpio_bus_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        wr0,
  input  logic [15:0] addr0,
  input  logic [31:0] wdata0,
  output logic        ack0,
  input  logic        req1,
  input  logic        wr1,
  input  logic [15:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack1,
  output logic [31:0] rdata,
  output logic [1:0]  gnt,
  output logic        busy,
  gpio_bus_arbiter_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETUP  = 3'd1;
  localparam logic [2:0] S_STROBE = 3'd2;
  localparam logic [2:0] S_HOLD   = 3'd3;
  localparam logic [2:0] S_ACK    = 3'd4;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);

  logic [2:0] state;
  logic [3:0] cnt;
  logic       last;
  logic       wr_q;
  logic       win1;

  // Requester 1 wins when alone, or when both ask and 0 went last.
  assign win1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      last         <= 1'b1;
      wr_q         <= 1'b0;
      gnt          <= 2'b00;
      busy         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata        <= 32'h0;
      bus.saddress <= 16'h0;
      bus.sdata_in <= 32'h0;
      bus.srd      <= 1'b0;
      bus.swr      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req0 | req1) begin
          last         <= win1;
          wr_q         <= win1 ? wr1 : wr0;
          bus.saddress <= win1 ? addr1 : addr0;
          bus.sdata_in <= win1 ? wdata1 : wdata0;
          gnt          <= win1 ? 2'b10 : 2'b01;
          busy         <= 1'b1;
          // Loaded with the full count: the grant cycle itself is an extra
          // setup cycle, keeping the bus stable before the strobe rises.
          cnt          <= SETUP_LD;
          state        <= S_SETUP;
        end
        S_SETUP: if (cnt == 4'd0) begin
          bus.srd <= ~wr_q;
          bus.swr <= wr_q;
          cnt     <= STROBE_LD;
          state   <= S_STROBE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        S_STROBE: if (cnt == 4'd0) begin
          bus.srd <= 1'b0;
          bus.swr <= 1'b0;
          state   <= S_HOLD;
        end else begin
          cnt <= cnt - 4'd1;
        end
        S_HOLD: begin
          if (!wr_q) rdata <= bus.sdata_out;
          ack0  <= gnt[0];
          ack1  <= gnt[1];
          state <= S_ACK;
        end
        S_ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          gnt   <= 2'b00;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter: default-timing DUT plus a SETUP=3/STROBE=4 DUT.
module tb_gpio_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, wr0 = 0, req1 = 0, wr1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, busy;
  logic [31:0] rdata;
  logic [1:0]  gnt;

  gpio_bus_arbiter_if bus();
  logic [31:0] slave_q = 32'h0;
  logic        use_alt = 1'b0;
  assign bus.sdata_out = use_alt ? 32'hFFFF_FFFF : slave_q;
  always @(negedge bus.srd)
    slave_q = (bus.saddress == 16'h0168) ? 32'h0001_4000 : 32'hBAD0_0000;

  gpio_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .gnt(gnt), .busy(busy), .bus(bus)
  );

  logic        p_req0 = 0, p_ack0, p_ack1, p_busy;
  logic [31:0] p_rdata;
  logic [1:0]  p_gnt;
  gpio_bus_arbiter_if pbus();
  assign pbus.sdata_out = 32'h0;

  gpio_bus_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(4)) dut_p (
    .clk(clk), .reset(reset),
    .req0(p_req0), .wr0(1'b1), .addr0(16'h0040), .wdata0(32'h1234_5678), .ack0(p_ack0),
    .req1(1'b0), .wr1(1'b0), .addr1(16'h0), .wdata1(32'h0), .ack1(p_ack1),
    .rdata(p_rdata), .gnt(p_gnt), .busy(p_busy), .bus(pbus)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int gt[4];
    logic [1:0] gv[4];
    int ng, nack, ovl, rise, fall, ackt, g2;
    logic [1:0] pg;

    tick(); tick();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", {30'h0, bus.srd, bus.swr}, 0);
    chk("rst_acks", {30'h0, ack0, ack1}, 0);
    chk("rst_saddress", 32'(bus.saddress), 0);
    chk("rst_sdata_in", bus.sdata_in, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1'b0;
    tick();

    // Single write
    req0 = 1; wr0 = 1; addr0 = 16'h016C; wdata0 = 32'h0002_C000;
    tick(); // E
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_busy", 32'(busy), 1);
    tick(); // E+1
    chk("wr_saddress", 32'(bus.saddress), 32'h016C);
    chk("wr_sdata_in", bus.sdata_in, 32'h0002_C000);
    chk("wr_swr_e1", {30'h0, bus.srd, bus.swr}, 0);
    tick(); chk("wr_swr_e2", {30'h0, bus.srd, bus.swr}, 1);
    tick(); chk("wr_swr_e3", {30'h0, bus.srd, bus.swr}, 1);
    tick(); chk("wr_swr_e4", {30'h0, bus.srd, bus.swr}, 0);
    chk("wr_hold_addr", 32'(bus.saddress), 32'h016C);
    chk("wr_ack_e4", {30'h0, ack0, ack1}, 0);
    tick(); chk("wr_ack_e5", {30'h0, ack0, ack1}, 2);
    req0 = 0;
    tick();
    chk("wr_ack_e6", {30'h0, ack0, ack1}, 0);
    chk("wr_idle_gnt", 32'(gnt), 0);
    chk("wr_idle_busy", 32'(busy), 0);
    chk("wr_keep_addr", 32'(bus.saddress), 32'h016C);
    tick();

    // Read from requester 1
    req1 = 1; wr1 = 0; addr1 = 16'h0168; wdata1 = 32'h0;
    tick(); chk("rd_gnt", 32'(gnt), 32'h2);
    tick();
    tick(); chk("rd_srd", {30'h0, bus.srd, bus.swr}, 2);
    tick(); chk("rd_gnt_mid", 32'(gnt), 32'h2);
    tick(); chk("rd_hold", {30'h0, bus.srd, bus.swr}, 0);
    tick();
    chk("rd_ack", {30'h0, ack0, ack1}, 1);
    chk("rd_rdata", rdata, 32'h0001_4000);
    req1 = 0; use_alt = 1;
    tick(); tick(); tick();
    chk("rd_rdata_held", rdata, 32'h0001_4000);
    use_alt = 0;

    // Contention: both held continuously
    req0 = 1; req1 = 1; wr0 = 1; wr1 = 1;
    ng = 0; nack = 0; ovl = 0; pg = gnt;
    for (int n = 1; n <= 28; n++) begin
      tick();
      if (gnt != 2'b00 && pg == 2'b00 && ng < 4) begin gt[ng] = n; gv[ng] = gnt; ng++; end
      pg = gnt;
      if (ack0 | ack1) nack++;
      if ((ack0 & ack1) | (bus.srd & bus.swr)) ovl++;
    end
    req0 = 0; req1 = 0;
    chk("cont_ngrants", 32'(ng), 4);
    chk("cont_g0", {gt[0][29:0], gv[0]}, {30'd1, 2'b01});
    chk("cont_g1", {gt[1][29:0], gv[1]}, {30'd8, 2'b10});
    chk("cont_g2", {gt[2][29:0], gv[2]}, {30'd15, 2'b01});
    chk("cont_g3", {gt[3][29:0], gv[3]}, {30'd22, 2'b10});
    chk("cont_acks", 32'(nack), 4);
    chk("cont_overlap", 32'(ovl), 0);
    tick(); tick();

    // Request dropped during SETUP
    req0 = 1; wr0 = 1; addr0 = 16'h0010; wdata0 = 32'hA5A5_0001;
    tick(); chk("drop_gnt", 32'(gnt), 32'h1);
    tick(); req0 = 0;
    tick(); chk("drop_swr", {30'h0, bus.srd, bus.swr}, 1);
    tick(); tick();
    tick(); chk("drop_ack", {30'h0, ack0, ack1}, 2);
    tick(); tick();

    // Reset in first STROBE cycle
    req0 = 1; wr0 = 1; addr0 = 16'h0020; wdata0 = 32'h0BAD_F00D;
    tick(); tick();
    tick(); chk("rstmid_swr", {30'h0, bus.srd, bus.swr}, 1);
    reset = 1; req1 = 1; wr1 = 1;
    #1;
    chk("rstmid_strobes", {30'h0, bus.srd, bus.swr}, 0);
    chk("rstmid_gnt_busy", {29'h0, gnt, busy}, 0);
    chk("rstmid_acks", {30'h0, ack0, ack1}, 0);
    chk("rstmid_saddress", 32'(bus.saddress), 0);
    chk("rstmid_sdata_in", bus.sdata_in, 0);
    tick();
    reset = 0;
    tick(); chk("rstmid_first_gnt", 32'(gnt), 32'h1);
    req0 = 0; req1 = 0;
    for (int n = 0; n < 8; n++) tick();

    // Parameter sweep DUT: SETUP=3, STROBE=4
    p_req0 = 1;
    rise = 0; fall = 0; ackt = 0; g2 = 0; pg = p_gnt;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 1) chk("p_gnt", 32'(p_gnt), 32'h1);
      if (pbus.swr && rise == 0) rise = n;
      if (!pbus.swr && rise != 0 && fall == 0) fall = n;
      if (p_ack0 && ackt == 0) ackt = n;
      if (n > 1 && p_gnt != 2'b00 && pg == 2'b00 && g2 == 0) g2 = n;
      pg = p_gnt;
    end
    p_req0 = 0;
    chk("p_strobe_rise", 32'(rise), 5);
    chk("p_strobe_width", 32'(fall - rise), 4);
    chk("p_ack_time", 32'(ackt), 10);
    chk("p_period", 32'(g2 - 1), 11);
    for (int n = 0; n < 12; n++) tick();
    chk("p_idle", {29'h0, p_gnt, p_busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/gpio_bus_arbiter.md
# gpio_bus_arbiter

Arbitrates between two requesters for the single slave bus of the GPIO emulator. The requesters are, for example, a host bridge and an autonomous poller. The block accepts word-wide read/write requests and grants them round-robin. It drives `saddress`/`sdata_in`/`srd`/`swr` with defined setup, strobe and hold phases. It captures `sdata_out` for reads and returns a one-cycle acknowledge to the granted requester. It sits directly in front of the GPIO emulator and is the only master of its bus.

## Interface
- `SETUP_CYCLES`, default 1: cycles that address/data are valid before the strobe rises; legal range 1..15.
- `STROBE_CYCLES`, default 2: cycles that `srd`/`swr` is held high; legal range 1..15.
- `clk  in  1`: the only clock.
- `reset  in  1`: asynchronous, active-high reset.
- `req0  in  1`: request from requester 0; held high until `ack0`.
- `wr0  in  1`: 1 = write, 0 = read; sampled with `req0` at grant.
- `addr0  in  16`: bus address, sampled at grant.
- `wdata0  in  32`: write data, sampled at grant.
- `ack0  out  1`: one-cycle completion pulse.
- `req1`, `wr1`, `addr1`, `wdata1`, `ack1`: same as the requester-0 ports, for requester 1.
- `rdata  out  32`: read data, valid in the `ack0`/`ack1` cycle; holds its value until the next read completes.
- `gnt  out  2`: one-hot owner of the current transaction; 0 when idle.
- `busy  out  1`: high in every state except IDLE.
- `saddress  out  16`: slave address.
- `sdata_in  out  32`: slave write data.
- `srd  out  1`: slave read strobe; the slave acts on its falling edge.
- `swr  out  1`: slave write strobe; the slave acts on its falling edge.
- `sdata_out  in  32`: slave read data.

## Operation
- **FSM states:** IDLE, SETUP, STROBE, HOLD, ACK. All outputs are registered.
- **IDLE:**
  - If any `reqN` is high, pick the winner and latch its `wr`, `addr` and `wdata`.
  - Set `gnt` to the winner, drive `saddress`/`sdata_in` from the latched values, and go to SETUP.
  - `sdata_in` is driven with the latched `wdata` for reads as well; the slave ignores it.
- **Round-robin arbitration:**
  - A 1-bit `last` register records the previous winner.
  - If both requesters are asserted, the requester that is not `last` wins. If only one is asserted, it wins.
  - `last` updates at grant.
- **SETUP:** strobes low; count `SETUP_CYCLES` cycles, then go to STROBE.
- **STROBE:** `srd` (read) or `swr` (write) high for `STROBE_CYCLES` cycles, then go to HOLD. Exactly one strobe is ever high.
- **HOLD:**
  - One cycle with both strobes low and address/data still held, so the slave's falling-edge action sees a stable bus.
  - On leaving HOLD, a read loads `rdata` from `sdata_out`.
- **ACK:**
  - `ackN` for the granted requester is high for exactly one cycle.
  - Then go to IDLE; `gnt` clears and `saddress`/`sdata_in` keep their last values.
- **Request handling:**
  - A request dropped mid-transaction does not abort it; the transaction completes and the ack is still issued.
  - A `req` still high in the IDLE cycle after ACK is a new request, so back-to-back transactions run with one IDLE cycle between them.
- **Phase counter:** one 4-bit down-counter shared by the SETUP and STROBE phases.
- **Reset values** (asserted asynchronously, in any state):
  - State goes to IDLE.
  - `srd`, `swr`, `ack0`, `ack1`, `busy` = 0; `gnt` = 0.
  - `saddress`, `sdata_in`, `rdata` = 0.
  - `last` = 1, so requester 0 wins the first contested grant.
- **Reset during STROBE:** the strobe falls asynchronously, which produces a slave edge; this is accepted behaviour. No ack is issued for the aborted transaction.

## Timing
- Latency: edge E samples `req` in IDLE.
  - SETUP starts at E+1.
  - The strobe is high from edge E+1+SETUP_CYCLES through edge E+1+SETUP_CYCLES+STROBE_CYCLES.
  - HOLD lasts one cycle; ACK is high after edge E+2+SETUP_CYCLES+STROBE_CYCLES.
  - Defaults: the strobe is high for cycles 3–4 after E and the ack comes in cycle 5.
- Transaction period, including the mandatory IDLE cycle: 4+SETUP_CYCLES+STROBE_CYCLES clocks (7 at the defaults).
- `saddress`/`sdata_in` are stable from SETUP entry through the end of HOLD.
- `ack0` and `ack1` are never high together; the granted requester's ack coincides with valid `rdata` for reads.

## Test plan
- **Single write:** `req0`=1, `wr0`=1, `addr0`=0x016C, `wdata0`=0x0002C000.
  - Required: `saddress`=0x016C and `sdata_in`=0x0002C000 from E+1; `swr` high at E+2 and E+3 only; `ack0` in cycle E+5; `srd` never high.
- **Read:** `req1`=1, `wr1`=0, `addr1`=0x0168, slave `sdata_out`=0x00014000 after the `srd` fall.
  - Required: `rdata`=0x00014000 with `ack1`; `rdata` unchanged afterwards; `gnt`=2'b10 during the transaction.
- **Contention:** `req0` and `req1` held high continuously.
  - Required grant order: 0, 1, 0, 1, 7 clocks apart, with exactly one ack per transaction.
- **Request dropped mid-transaction:** `req0` deasserted during SETUP.
  - Required: the transaction still strobes and `ack0` still pulses.
- **Reset mid-transaction:** `reset` asserted in the first STROBE cycle of a write.
  - Required: all outputs are immediately at reset values, with no ack. After release with both requesters asserted, requester 0 is granted first.
- **Parameter sweep:** SETUP_CYCLES=3, STROBE_CYCLES=4.
  - Required: strobe width 4 clocks, ack at E+9, period 11 clocks.
